// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   rx_state_t      : receiver FSM state encoding
//   PAR_EVEN/PAR_ODD: values of the parity-type select input
//   expected_parity : parity bit a correct frame carries for a given data XOR
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Even parity sends the XOR of the data bits; odd parity sends its inverse.
    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        logic result;
        case (par_typ)
            PAR_EVEN: result = data_xor;
            PAR_ODD:  result = ~data_xor;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
// Bit-period timing and noise-tolerant sampling for the UART receiver.
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_enable          : high while a frame is being received; low holds the
//                       edge counter at zero so a frame starts at edge 0
//   i_rx_in           : synchronized serial line
//   i_prescale        : latched clocks-per-bit (even, 8..32)
//   o_sampled_bit     : majority vote of the three mid-bit samples
//   o_sample_done     : one-cycle pulse on the cycle o_sampled_bit is fresh
//   o_bit_end         : high on the last clock of the current bit period
// ---------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_rx_in,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_sampled_bit,
    output logic                      o_sample_done,
    output logic                      o_bit_end
);

    localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
    localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] half;
    logic                      tap0;
    logic                      tap1;
    logic                      tap2;
    logic                      vote;

    assign half      = i_prescale >> 1;
    assign o_bit_end = i_enable && (edge_cnt == i_prescale - ONE);
    assign vote      = (tap0 & tap1) | (tap0 & tap2) | (tap1 & tap2);

    // Edge counter plus three taps straddling mid-bit; the vote is registered
    // one clock after the last tap so it never sees a half-updated tap set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            edge_cnt      <= '0;
            tap0          <= 1'b1;
            tap1          <= 1'b1;
            tap2          <= 1'b1;
            o_sampled_bit <= 1'b1;
            o_sample_done <= 1'b0;
        end else begin
            o_sample_done <= 1'b0;
            if (!i_enable) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= o_bit_end ? '0 : edge_cnt + ONE;
                if (edge_cnt == half - ONE) begin
                    tap0 <= i_rx_in;
                end
                if (edge_cnt == half) begin
                    tap1 <= i_rx_in;
                end
                if (edge_cnt == half + ONE) begin
                    tap2 <= i_rx_in;
                end
                if (edge_cnt == half + TWO) begin
                    o_sampled_bit <= vote;
                    o_sample_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_rx_in        : synchronized serial line, idle high
//   i_prescale     : clocks per bit (even, 8..32), latched at frame start
//   i_par_en       : frame carries a parity bit, latched at frame start
//   i_par_typ      : 0 even / 1 odd parity, latched at frame start
//   o_data         : last good byte, held until the next good frame
//   o_data_valid   : one-cycle pulse when o_data updates
//   o_par_err      : one-cycle pulse at frame end on parity mismatch
//   o_stop_err     : one-cycle pulse at frame end when the stop bit was 0
// ---------------------------------------------------------------------------
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx_in,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    input  logic                      i_par_en,
    input  logic                      i_par_typ,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_data_valid,
    output logic                      o_par_err,
    output logic                      o_stop_err
);

    localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_t                 state;
    rx_state_t                 next_state;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      par_en_q;
    logic                      par_typ_q;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_fail;
    logic                      stop_fail;
    logic                      sampled_bit;
    logic                      sample_done;
    logic                      bit_end;
    logic                      sampler_en;
    logic                      stop_bad;

    assign sampler_en = (state != IDLE);

    // At P=8 the stop-bit vote lands on the same clock as the bit end, so the
    // fresh vote is folded in alongside the already-registered flag.
    assign stop_bad = stop_fail || (sample_done && !sampled_bit);

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (sampler_en),
        .i_rx_in      (i_rx_in),
        .i_prescale   (prescale_q),
        .o_sampled_bit(sampled_bit),
        .o_sample_done(sample_done),
        .o_bit_end    (bit_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A start bit that votes high was a glitch and is dropped silently.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!i_rx_in) next_state = START;
            START:   if (bit_end)  next_state = sampled_bit ? IDLE : DATA;
            DATA:    if (bit_end && (bit_cnt == LAST_BIT)) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end)  next_state = STOP;
            STOP:    if (bit_end)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Frame datapath: config capture, shift register, error flags and the
    // end-of-frame result pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            par_fail     <= 1'b0;
            stop_fail    <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stop_err   <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_par_err    <= 1'b0;
            o_stop_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!i_rx_in) begin
                        prescale_q <= i_prescale;
                        par_en_q   <= i_par_en;
                        par_typ_q  <= i_par_typ;
                        bit_cnt    <= '0;
                        par_fail   <= 1'b0;
                        stop_fail  <= 1'b0;
                    end
                end
                DATA: begin
                    if (sample_done) begin
                        shift_reg[bit_cnt] <= sampled_bit;
                    end
                    if (bit_end) begin
                        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (sample_done && (sampled_bit != expected_parity(^shift_reg, par_typ_q))) begin
                        par_fail <= 1'b1;
                    end
                end
                STOP: begin
                    if (sample_done && !sampled_bit) begin
                        stop_fail <= 1'b1;
                    end
                    if (bit_end) begin
                        if (par_fail || stop_bad) begin
                            o_par_err  <= par_fail;
                            o_stop_err <= stop_bad;
                        end else begin
                            o_data       <= shift_reg;
                            o_data_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fsm
// Directed bench for uart_rx_fsm. Each frame pushes its expected result
// (data, flags, and the clock it must appear on) to a scoreboard; a negedge
// monitor pops and checks whenever the DUT pulses any result output.
// ---------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_rx_in;
    logic [PW-1:0] i_prescale;
    logic          i_par_en;
    logic          i_par_typ;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          o_par_err;
    logic          o_stop_err;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic          par_err;
        logic          stop_err;
        int            cycle;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_compared = 0;
    int            n_mismatched = 0;
    int            rx_free = 0;
    logic [DW-1:0] last_good = '0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    uart_rx_fsm #(
        .DATA_WIDTH(DW),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx_in     (i_rx_in),
        .i_prescale  (i_prescale),
        .i_par_en    (i_par_en),
        .i_par_typ   (i_par_typ),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_par_err   (o_par_err),
        .o_stop_err  (o_stop_err)
    );

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    // Pops one scoreboard entry per pulsing cycle, so a pulse lasting two
    // cycles or one nobody expected shows up as an unexpected pulse.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checkValue("unexpected_pulse", {29'd0, o_data_valid, o_par_err, o_stop_err}, 32'd0);
        end else begin
            e = sb.pop_front();
            checkValue("pulse_cycle", cyc, e.cycle);
            checkValue("data", {24'd0, o_data}, {24'd0, e.data});
            checkValue("data_valid", {31'd0, o_data_valid}, {31'd0, e.valid});
            checkValue("par_err", {31'd0, o_par_err}, {31'd0, e.par_err});
            checkValue("stop_err", {31'd0, o_stop_err}, {31'd0, e.stop_err});
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && (o_data_valid || o_par_err || o_stop_err)) begin
            checkOutput();
        end
    end

    task automatic checkReset(input string tag);
        checkValue({tag, "_data"}, {24'd0, o_data}, 32'd0);
        checkValue({tag, "_valid"}, {31'd0, o_data_valid}, 32'd0);
        checkValue({tag, "_par_err"}, {31'd0, o_par_err}, 32'd0);
        checkValue({tag, "_stop_err"}, {31'd0, o_stop_err}, 32'd0);
    endtask

    task automatic idleCycles(input int n);
        i_rx_in = 1'b1;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Called #1 after a clock edge. The receiver can only see the start bit
    // once it is back in IDLE, which rx_free tracks across frames.
    task automatic applyStimulus(input logic [7:0] data, input int p, input logic par_en,
                                 input logic par_typ, input logic bad_par, input logic bad_stop);
        logic [10:0] bits;
        int          nbits;
        int          detect;
        logic        good;
        exp_t        e;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        if (par_en) begin
            bits[9]  = (^data) ^ par_typ ^ bad_par;
            bits[10] = ~bad_stop;
            nbits    = 11;
        end else begin
            bits[9]  = ~bad_stop;
            nbits    = 10;
        end
        detect  = (cyc + 1 > rx_free) ? cyc + 1 : rx_free;
        e.cycle = detect + nbits * p;
        rx_free = e.cycle + 1;
        good    = !(par_en && bad_par) && !bad_stop;
        if (good) last_good = data;
        e.data     = last_good;
        e.valid    = good;
        e.par_err  = par_en && bad_par;
        e.stop_err = bad_stop;
        sb.push_back(e);
        i_prescale = PW'(p);
        i_par_en   = par_en;
        i_par_typ  = par_typ;
        for (int b = 0; b < nbits; b++) begin
            i_rx_in = bits[b];
            repeat (p) @(posedge i_clk);
            #1;
            if (b == 0) begin
                i_prescale = (p == 8) ? 6'd16 : 6'd8;
                i_par_en   = ~par_en;
                i_par_typ  = ~par_typ;
            end
        end
    endtask

    task automatic sendGlitch(input int p, input int low_cycles);
        int detect;
        i_prescale = PW'(p);
        i_par_en   = 1'b0;
        i_rx_in    = 1'b0;
        detect     = (cyc + 1 > rx_free) ? cyc + 1 : rx_free;
        rx_free    = detect + p + 1;
        repeat (low_cycles) @(posedge i_clk);
        #1;
        i_rx_in = 1'b1;
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (sb.size() == 0) break;
            @(posedge i_clk);
        end
        @(posedge i_clk);
        #1;
        checkValue(tag, sb.size(), 32'd0);
    endtask

    initial begin
        logic [9:0] abort_bits;
        logic [7:0] abort_data;

        i_rst      = 1'b1;
        i_rx_in    = 1'b1;
        i_prescale = 6'd8;
        i_par_en   = 1'b0;
        i_par_typ  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checkReset("reset");
        i_rst = 1'b0;
        idleCycles(5);

        $display("[TB] P=8 no parity 0xA5");
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(4);

        $display("[TB] P=16 even parity 0x3C good then bad parity");
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        idleCycles(4);
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCycles(4);

        $display("[TB] P=16 odd parity 0xFF with stop 0, then 0x01");
        applyStimulus(8'hFF, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        idleCycles(4);
        applyStimulus(8'h01, 16, 1'b1, 1'b1, 1'b0, 1'b0);
        idleCycles(4);

        $display("[TB] start glitch then 0x5A");
        sendGlitch(16, 3);
        idleCycles(24);
        applyStimulus(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(4);

        $display("[TB] back-to-back 0x11 0x22 0x33 at P=32");
        applyStimulus(8'h11, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h22, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h33, 32, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(4);
        waitDrain("drained_before_reset", 2000);

        $display("[TB] reset during data bit 4 of 0xC3");
        abort_data = 8'hC3;
        abort_bits = {1'b1, abort_data, 1'b0};
        i_prescale = 6'd16;
        i_par_en   = 1'b0;
        for (int b = 0; b < 6; b++) begin
            i_rx_in = abort_bits[b];
            repeat ((b == 5) ? 8 : 16) @(posedge i_clk);
            #1;
        end
        i_rst   = 1'b1;
        i_rx_in = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checkReset("mid_frame_reset");
        i_rst     = 1'b0;
        rx_free   = 0;
        last_good = '0;
        idleCycles(40);

        applyStimulus(8'h7E, 16, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(4);
        waitDrain("drained_at_end", 2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
